fft_demux_sched: RTL

Sample-stream scheduler for the 1xN FFT input demux (16-way by default). It accepts a valid/ready sample stream and assigns each sample a lane select, either in natural or bit-reversed order. It presents the sample to the demux and, once all N lanes of a group have landed, hands the group to the FFT engine with a valid/ack handshake. It also counts groups per frame and flags frame boundaries; it sits between the sample source and the demux.

---
 rtl/fft_demux_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fft_demux_sched.sv
// fft_demux_sched: sample-stream scheduler for the 1xN FFT input demux.
// Accepts a valid/ready sample stream, registers each accepted beat onto the
// demux with a lane select, and hands a full group of N lanes to the FFT
// engine through a grp_valid/grp_ack handshake. Groups are counted per frame
// and frame boundaries are flagged with one-cycle pulses.
//
// Optional feature macro: FFT_DEMUX_BITREV_EN
//   defined   -> dmx_sel is the bit-reverse of the lane counter
//   undefined -> dmx_sel is the lane counter (natural order)
module fft_demux_sched #(
    parameter int DATA_WIDTH   = 8,
    parameter int SEL_WIDTH    = 4,
    parameter int FRAME_GROUPS = 128
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_WIDTH-1:0]           s_data,
    input  logic                            sw_clear,
    output logic                            dmx_valid,
    output logic [SEL_WIDTH-1:0]            dmx_sel,
    output logic [DATA_WIDTH-1:0]           dmx_data,
    output logic                            grp_valid,
    input  logic                            grp_ack,
    output logic [$clog2(FRAME_GROUPS)-1:0] grp_index,
    output logic                            frame_start,
    output logic                            frame_done,
    output logic                            busy
);

    localparam int GRP_WIDTH = $clog2(FRAME_GROUPS);
    localparam logic [SEL_WIDTH-1:0] LANE_LAST = '1;
    localparam logic [GRP_WIDTH-1:0] GRP_LAST  = GRP_WIDTH'(FRAME_GROUPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_SETTLE,
        ST_WAIT_ACK
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SEL_WIDTH-1:0]    r_lane_cnt;
    logic [GRP_WIDTH-1:0]    r_grp_cnt;
    logic                    r_dmx_valid;
    logic [SEL_WIDTH-1:0]    r_dmx_sel;
    logic [DATA_WIDTH-1:0]   r_dmx_data;
    logic                    r_frame_start;
    logic                    r_frame_done;

    logic                    w_ready;
    logic                    w_accept;
    logic                    w_grp_take;
    logic                    w_lane_last;
    logic [SEL_WIDTH-1:0]    w_sel;

    // Reverse the bit order of a lane number over SEL_WIDTH bits.
    function automatic logic [SEL_WIDTH-1:0] bitrev(input logic [SEL_WIDTH-1:0] v);
        logic [SEL_WIDTH-1:0] r;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            r[i] = v[SEL_WIDTH-1-i];
        end
        return r;
    endfunction

    // Ready depends on state only, so the source never sees a valid->ready loop.
    assign w_ready     = (r_state == ST_IDLE) || (r_state == ST_FILL);
    assign w_accept    = s_valid && w_ready;
    assign w_grp_take  = (r_state == ST_WAIT_ACK) && grp_ack;
    assign w_lane_last = (r_lane_cnt == LANE_LAST);

`ifdef FFT_DEMUX_BITREV_EN
    assign w_sel = bitrev(r_lane_cnt);
`else
    assign w_sel = r_lane_cnt;
`endif

    // Next-state decode; sw_clear overrides every other transition.
    always_comb begin
        // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_FILL: begin
                if (w_accept) begin
                    w_state_nxt = w_lane_last ? ST_SETTLE : ST_FILL;
                end
            end
            ST_SETTLE:   w_state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (grp_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:     w_state_nxt = ST_IDLE;
        endcase
        if (sw_clear) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lane and group counters; both wrap naturally at their terminal counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_cnt <= '0;
            r_grp_cnt  <= '0;
        end else if (sw_clear) begin
            r_lane_cnt <= '0;
            r_grp_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_lane_cnt <= r_lane_cnt + 1'b1;
            end
            if (w_grp_take) begin
                r_grp_cnt <= (r_grp_cnt == GRP_LAST) ? '0 : r_grp_cnt + 1'b1;
            end
        end
    end

    // Registered demux drive and frame pulses; data/sel hold between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dmx_valid   <= 1'b0;
            r_dmx_sel     <= '0;
            r_dmx_data    <= '0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
        end else if (sw_clear) begin
            r_dmx_valid   <= 1'b0;
            r_dmx_sel     <= '0;
            r_dmx_data    <= '0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_dmx_valid   <= w_accept;
            r_frame_start <= w_accept && (r_lane_cnt == '0) && (r_grp_cnt == '0);
            r_frame_done  <= w_grp_take && (r_grp_cnt == GRP_LAST);
            if (w_accept) begin
                r_dmx_sel  <= w_sel;
                r_dmx_data <= s_data;
            end
        end
    end

    assign s_ready     = w_ready;
    assign grp_valid   = (r_state == ST_WAIT_ACK);
    assign busy        = (r_state != ST_IDLE);
    assign grp_index   = r_grp_cnt;
    assign dmx_valid   = r_dmx_valid;
    assign dmx_sel     = r_dmx_sel;
    assign dmx_data    = r_dmx_data;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;

endmodule
